gfx_axi_pixel_writer: RTL and testbench

//  Responder/sink for the gfx pixel-write stream (valid/ready, x, y, color, meta)

---
 rtl/gfx_pkg.sv | 21 ++
 rtl/gfx_fb_addr.sv | 38 +++
 rtl/gfx_axi_pixel_writer.sv | 140 ++++++++++++++
 tb/tb_gfx_axi_pixel_writer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared definitions for the gfx pixel pipeline: framebuffer addressing,
// AXI response codes and the pixel-writer state encoding.
package gfx_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Linear word address of pixel (x,y); callers truncate to their bus width.
    function automatic logic [31:0] fb_addr(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] width,
        input logic [31:0] base
    );
        return base + y * width + x;
    endfunction

endpackage

// File: rtl/gfx_fb_addr.sv
// Framebuffer address generator: combinational on-screen check plus an
// address register loaded only for on-screen pixels.
module gfx_fb_addr
    import gfx_pkg::*;
#(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int FB_BASE    = 0,
    parameter int ADDR_WIDTH = 20,
    parameter int X_BITS     = $clog2(FB_WIDTH),
    parameter int Y_BITS     = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [X_BITS-1:0]     x,
    input  logic [Y_BITS-1:0]     y,
    output logic                  in_range,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [31:0] x_ext;
    logic [31:0] y_ext;

    assign x_ext    = 32'(x);
    assign y_ext    = 32'(y);
    assign in_range = (x_ext < 32'(FB_WIDTH)) && (y_ext < 32'(FB_HEIGHT));

    // The cast wraps the address modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr <= '0;
        end else if (load && in_range) begin
            addr <= ADDR_WIDTH'(fb_addr(x_ext, y_ext, 32'(FB_WIDTH), 32'(FB_BASE)));
        end
    end

endmodule

// File: rtl/gfx_axi_pixel_writer.sv
// Converts accepted gfx pixels into single-beat AXI writes of framebuffer
// words; off-screen pixels are discarded and counted.
module gfx_axi_pixel_writer
    import gfx_pkg::*;
#(
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int META_BITS      = 4,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int FB_BASE        = 0,
    parameter int DROP_CNT_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          gfx_valid,
    output logic                          gfx_ready,
    input  logic [$clog2(FB_WIDTH)-1:0]   gfx_x,
    input  logic [$clog2(FB_HEIGHT)-1:0]  gfx_y,
    input  logic [PIXEL_BITS-1:0]         gfx_color,
    input  logic [META_BITS-1:0]          gfx_meta,
    output logic [AXI_ADDR_WIDTH-1:0]     axi_awaddr,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]     axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready,
    output logic                          busy,
    output logic                          wr_err,
    output logic [DROP_CNT_BITS-1:0]      drop_cnt
);

    if (AXI_DATA_WIDTH < PIXEL_BITS + META_BITS) begin : g_width_check
        $error("AXI_DATA_WIDTH too narrow for meta+color");
    end

    logic [1:0] state;
    logic       ready_q;
    logic       aw_done;
    logic       w_done;
    logic       in_range;
    logic       accept;
    logic       aw_fire;
    logic       w_fire;
    logic       aw_all;
    logic       w_all;

    assign accept    = gfx_valid & ready_q;
    assign aw_fire   = axi_awvalid & axi_awready;
    assign w_fire    = axi_wvalid & axi_wready;
    assign aw_all    = aw_done | aw_fire;
    assign w_all     = w_done | w_fire;
    assign gfx_ready = ready_q;
    assign busy      = (state != ST_IDLE);
    assign axi_wstrb = '1;

    gfx_fb_addr #(
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT),
        .FB_BASE    (FB_BASE),
        .ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_fb_addr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .x        (gfx_x),
        .y        (gfx_y),
        .in_range (in_range),
        .addr     (axi_awaddr)
    );

    // Ready is registered so it is low throughout reset and rises one cycle after release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ready_q     <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_wdata   <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wr_err      <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (in_range) begin
                            axi_wdata   <= AXI_DATA_WIDTH'({gfx_meta, gfx_color});
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            ready_q     <= 1'b0;
                            state       <= ST_WRITE;
                        end else if (drop_cnt != '1) begin
                            drop_cnt <= drop_cnt + DROP_CNT_BITS'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (aw_fire) axi_awvalid <= 1'b0;
                    if (w_fire)  axi_wvalid  <= 1'b0;
                    if (aw_all && w_all) begin
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        axi_bready <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        aw_done <= aw_all;
                        w_done  <= w_all;
                    end
                end
                ST_RESP: begin
                    if (axi_bvalid) begin
                        if (axi_bresp != AXI_RESP_OKAY) wr_err <= 1'b1;
                        axi_bready <= 1'b0;
                        ready_q    <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    axi_awvalid <= 1'b0;
                    axi_wvalid  <= 1'b0;
                    axi_bready  <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_axi_pixel_writer.sv
// Directed and randomized-backpressure bench for gfx_axi_pixel_writer with a
// transaction-level model checked every cycle.
module tb_gfx_axi_pixel_writer;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_BASE   = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        gfx_valid = 1'b0;
    logic        gfx_ready;
    logic [9:0]  gfx_x = '0;
    logic [8:0]  gfx_y = '0;
    logic [11:0] gfx_color = '0;
    logic [3:0]  gfx_meta = '0;
    logic [19:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready = 1'b0;
    logic [15:0] axi_wdata;
    logic [1:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready = 1'b0;
    logic [1:0]  axi_bresp = 2'b00;
    logic        axi_bvalid = 1'b0;
    logic        axi_bready;
    logic        busy;
    logic        wr_err;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    gfx_axi_pixel_writer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .gfx_valid   (gfx_valid),
        .gfx_ready   (gfx_ready),
        .gfx_x       (gfx_x),
        .gfx_y       (gfx_y),
        .gfx_color   (gfx_color),
        .gfx_meta    (gfx_meta),
        .axi_awaddr  (axi_awaddr),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .busy        (busy),
        .wr_err      (wr_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state: pixels written vs. handshakes completed, plus expected AW/W payloads.
    logic        rst_q = 1'b0;
    int          acc, awn, wn, bn;
    logic [15:0] m_drop;
    logic        m_err;
    logic [19:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic        aw_hold_prev, w_hold_prev;
    logic [19:0] aw_addr_prev;
    logic [15:0] w_data_prev;

    always @(posedge clk) rst_q <= reset_n;

    always @(negedge clk) begin
        if (!rst_q) begin
            acc = 0; awn = 0; wn = 0; bn = 0;
            m_drop = '0; m_err = 1'b0;
            exp_addr_q.delete(); exp_data_q.delete();
            aw_hold_prev = 1'b0; w_hold_prev = 1'b0;
            checkOutput("rst_awvalid", axi_awvalid, 0);
            checkOutput("rst_wvalid", axi_wvalid, 0);
            checkOutput("rst_bready", axi_bready, 0);
            checkOutput("rst_ready", gfx_ready, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_wr_err", wr_err, 0);
            checkOutput("rst_drop_cnt", drop_cnt, 0);
            checkOutput("rst_awaddr", axi_awaddr, 0);
            checkOutput("rst_wdata", axi_wdata, 0);
        end else begin
            checkOutput("ready", gfx_ready, (acc == bn) ? 1 : 0);
            checkOutput("busy", busy, (acc != bn) ? 1 : 0);
            checkOutput("drop_cnt", drop_cnt, m_drop);
            checkOutput("wr_err", wr_err, m_err);
            if (axi_awvalid) checkOutput("aw_pending", (awn < acc) ? 1 : 0, 1);
            if (axi_wvalid) begin
                checkOutput("w_pending", (wn < acc) ? 1 : 0, 1);
                checkOutput("wstrb", axi_wstrb, 2'b11);
            end
            if (axi_bready) checkOutput("b_after_aw_w", (awn == acc && wn == acc && bn < acc) ? 1 : 0, 1);
            if (aw_hold_prev) begin
                checkOutput("aw_held", axi_awvalid, 1);
                checkOutput("aw_stable", axi_awaddr, aw_addr_prev);
            end
            if (w_hold_prev) begin
                checkOutput("w_held", axi_wvalid, 1);
                checkOutput("w_stable", axi_wdata, w_data_prev);
            end
            if (reset_n) begin
                if (gfx_valid && gfx_ready) begin
                    if (int'(gfx_x) < FB_WIDTH && int'(gfx_y) < FB_HEIGHT) begin
                        acc++;
                        exp_addr_q.push_back(20'(FB_BASE + int'(gfx_y) * FB_WIDTH + int'(gfx_x)));
                        exp_data_q.push_back({gfx_meta, gfx_color});
                    end else if (m_drop != 16'hFFFF) begin
                        m_drop = m_drop + 16'd1;
                    end
                end
                if (axi_awvalid && axi_awready) begin
                    awn++;
                    if (exp_addr_q.size() == 0) checkOutput("aw_unexpected", 1, 0);
                    else checkOutput("awaddr", axi_awaddr, exp_addr_q.pop_front());
                end
                if (axi_wvalid && axi_wready) begin
                    wn++;
                    if (exp_data_q.size() == 0) checkOutput("w_unexpected", 1, 0);
                    else checkOutput("wdata", axi_wdata, exp_data_q.pop_front());
                end
                if (axi_bready && axi_bvalid) begin
                    bn++;
                    if (axi_bresp != 2'b00) m_err = 1'b1;
                end
                aw_hold_prev = axi_awvalid && !axi_awready;
                w_hold_prev  = axi_wvalid && !axi_wready;
            end else begin
                aw_hold_prev = 1'b0;
                w_hold_prev  = 1'b0;
            end
            aw_addr_prev = axi_awaddr;
            w_data_prev  = axi_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and hold it until accepted; returns one cycle after acceptance.
    task automatic applyStimulus(input int x, input int y, input logic [11:0] c, input logic [3:0] m);
        logic got;
        got = 1'b0;
        gfx_x = 10'(x);
        gfx_y = 9'(y);
        gfx_color = c;
        gfx_meta = m;
        gfx_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = gfx_ready;
            step();
        end
        gfx_valid = 1'b0;
        if (!got) checkOutput("accept_timeout", got, 1);
    endtask

    task automatic waitIdle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = gfx_ready && !busy;
            step();
        end
        if (!idle) checkOutput("idle_timeout", idle, 1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        repeat (3) step();
        checkOutput("t0_ready_in_reset", gfx_ready, 0);
        reset_n = 1'b1;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1; axi_bresp = 2'b00;
        step();
        checkOutput("t0_ready_after_release", gfx_ready, 1);

        $display("[TB] test 1: single pixel");
        applyStimulus(3, 2, 12'hABC, 4'h5);
        checkOutput("t1_awvalid", axi_awvalid, 1);
        checkOutput("t1_wvalid", axi_wvalid, 1);
        checkOutput("t1_awaddr", axi_awaddr, 1283);
        checkOutput("t1_wdata", axi_wdata, 16'h5ABC);
        checkOutput("t1_wstrb", axi_wstrb, 2'b11);
        checkOutput("t1_ready_n1", gfx_ready, 0);
        step();
        checkOutput("t1_ready_n2", gfx_ready, 0);
        checkOutput("t1_bready", axi_bready, 1);
        checkOutput("t1_awvalid_off", axi_awvalid, 0);
        step();
        checkOutput("t1_ready_n3", gfx_ready, 1);
        checkOutput("t1_busy_n3", busy, 0);

        $display("[TB] test 2: awready backpressure");
        axi_awready = 1'b0;
        applyStimulus(10, 1, 12'h123, 4'h9);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_awvalid_held", axi_awvalid, 1);
            checkOutput("t2_awaddr", axi_awaddr, 650);
            checkOutput("t2_no_bready", axi_bready, 0);
            if (k > 0) checkOutput("t2_wvalid_dropped", axi_wvalid, 0);
            step();
        end
        axi_awready = 1'b1;
        step();
        checkOutput("t2_awvalid_off", axi_awvalid, 0);
        checkOutput("t2_bready", axi_bready, 1);
        waitIdle();

        $display("[TB] test 3: off-screen drops");
        applyStimulus(640, 0, 12'hFFF, 4'h1);
        checkOutput("t3_ready_after_drop", gfx_ready, 1);
        checkOutput("t3_no_aw_1", axi_awvalid, 0);
        applyStimulus(0, 480, 12'hFFF, 4'h1);
        checkOutput("t3_drop_cnt", drop_cnt, 2);
        checkOutput("t3_no_aw_2", axi_awvalid, 0);
        applyStimulus(639, 479, 12'h0F0, 4'h3);
        checkOutput("t3_awaddr_corner", axi_awaddr, 307199);
        checkOutput("t3_wdata_corner", axi_wdata, 16'h30F0);
        waitIdle();

        $display("[TB] test 4: sticky write error");
        axi_bresp = 2'b10;
        applyStimulus(1, 0, 12'h111, 4'h0);
        waitIdle();
        axi_bresp = 2'b00;
        checkOutput("t4_wr_err_set", wr_err, 1);
        applyStimulus(2, 0, 12'h222, 4'h0);
        waitIdle();
        checkOutput("t4_wr_err_sticky", wr_err, 1);

        $display("[TB] test 5: reset mid-write");
        axi_awready = 1'b0;
        applyStimulus(5, 5, 12'h555, 4'h5);
        checkOutput("t5_awvalid_before", axi_awvalid, 1);
        reset_n = 1'b0;
        step();
        checkOutput("t5_awvalid", axi_awvalid, 0);
        checkOutput("t5_wvalid", axi_wvalid, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_wr_err", wr_err, 0);
        reset_n = 1'b1;
        axi_awready = 1'b1;
        step();
        checkOutput("t5_ready_release", gfx_ready, 1);
        applyStimulus(1, 1, 12'hA5A, 4'h7);
        checkOutput("t5_awaddr", axi_awaddr, 641);
        checkOutput("t5_wdata", axi_wdata, 16'h7A5A);
        waitIdle();

        $display("[TB] test 6: random backpressure");
        begin
            logic rand_bp;
            rand_bp = 1'b1;
            fork
                begin
                    for (int p = 0; p < 1000; p++) begin
                        repeat ($urandom_range(0, 2)) step();
                        applyStimulus($urandom_range(0, 700), $urandom_range(0, 520),
                                      12'($urandom), 4'($urandom));
                    end
                    rand_bp = 1'b0;
                end
                begin
                    while (rand_bp) begin
                        step();
                        axi_awready = 1'($urandom_range(0, 1));
                        axi_wready  = 1'($urandom_range(0, 1));
                        axi_bvalid  = 1'($urandom_range(0, 1));
                        axi_bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                    end
                end
            join
        end
        axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1; axi_bresp = 2'b00;
        waitIdle();
        step();
        checkOutput("t6_addr_q_empty", exp_addr_q.size(), 0);
        checkOutput("t6_data_q_empty", exp_data_q.size(), 0);
        checkOutput("t6_aw_count", awn, acc);
        checkOutput("t6_b_count", bn, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
